// File: rtl/mem_resp_pkg.sv
// Shared widths, FSM state type and response-beat payload for the burst memory responder.
package mem_resp_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned LATENCY     = 4;
  localparam int unsigned BURST_LEN   = 8;
  localparam int unsigned BEAT_W      = $clog2(BURST_LEN);
  localparam int unsigned BLOCK_OFF_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned BLK_W       = ADDR_W - BLOCK_OFF_W;
  localparam int unsigned WORD_AW     = ADDR_W - 1;
  localparam int unsigned MEM_WORDS   = 1 << WORD_AW;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  // Byte address of a beat: block number, beat index, word-aligned LSB.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [BLK_W-1:0]  blk,
                                                  input logic [BEAT_W-1:0] beat);
    return {blk, beat, 1'b0};
  endfunction

endpackage

// File: rtl/resp_delay_pipe.sv
// Fixed-latency shift register of response beats with a registered, value-holding output stage.
module resp_delay_pipe
  import mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              any_valid_c
);

  beat_t stage_q [LATENCY];
  beat_t stage_d [LATENCY];
  beat_t out_q;
  beat_t out_d;

  always_comb begin
    stage_d[0] = {in_valid, in_data, in_addr, in_last};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    // Payload fields hold their last value while no beat is presented.
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (stage_q[LATENCY-1].valid) begin
      out_d = stage_q[LATENCY-1];
    end
    any_valid_c = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      any_valid_c = any_valid_c | stage_q[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
      out_q <= out_d;
    end
  end

  assign out_valid = out_q.valid;
  assign out_data  = out_q.data;
  assign out_addr  = out_q.addr;
  assign out_last  = out_q.last;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder: single reads/writes and block-burst reads, in-order fixed-latency responses.
module burst_mem_responder
  import mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              mem_we_c;
  logic              issue_valid_c;
  logic              issue_last_c;
  logic [ADDR_W-1:0] issue_addr_c;
  logic [DATA_W-1:0] issue_data_c;
  logic              pipe_any_valid_c;
  logic              unused_addr_lsb;

  // Byte lane select is meaningless for 16-bit word accesses.
  assign unused_addr_lsb = req_addr[0];
  assign accept_c        = req_valid & req_ready_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    blk_d         = blk_q;
    mem_we_c      = 1'b0;
    issue_valid_c = 1'b0;
    issue_last_c  = 1'b0;
    issue_addr_c  = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_wr) begin
            mem_we_c = 1'b1;
          end else if (req_burst) begin
            blk_d         = req_addr[ADDR_W-1:BLOCK_OFF_W];
            issue_valid_c = 1'b1;
            issue_addr_c  = beat_addr(req_addr[ADDR_W-1:BLOCK_OFF_W], '0);
            beat_d        = BEAT_W'(1);
            state_d       = BURST;
          end else begin
            issue_valid_c = 1'b1;
            issue_last_c  = 1'b1;
            issue_addr_c  = {req_addr[ADDR_W-1:1], 1'b0};
          end
        end
      end
      BURST: begin
        issue_valid_c = 1'b1;
        issue_addr_c  = beat_addr(blk_q, beat_q);
        issue_last_c  = (beat_q == BEAT_W'(BURST_LEN - 1));
        beat_d        = beat_q + BEAT_W'(1);
        if (issue_last_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    // Mirrors the next-cycle view of FSM, pipe stages and output register.
    busy_d      = (state_d == BURST) | issue_valid_c | pipe_any_valid_c;
  end

  // Read data is captured at issue, so later writes never alter an issued beat.
  assign issue_data_c = mem[issue_addr_c[ADDR_W-1:1]];

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[req_addr[ADDR_W-1:1]] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      blk_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      blk_q       <= blk_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  resp_delay_pipe u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (issue_valid_c),
    .in_data     (issue_data_c),
    .in_addr     (issue_addr_c),
    .in_last     (issue_last_c),
    .out_valid   (rsp_valid),
    .out_data    (rsp_data),
    .out_addr    (rsp_addr),
    .out_last    (rsp_last),
    .any_valid_c (pipe_any_valid_c)
  );

  assign req_ready = req_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: expected beats queued at accept, checked on the response channel.
module tb_burst_mem_responder;

  localparam int LAT = 4;
  localparam int BL  = 8;

  typedef struct {
    logic [15:0] data;
    logic [15:0] addr;
    logic        last;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_last;
  logic        busy;

  int          checks;
  int          errors;
  int          cyc;
  int          beats_seen;
  exp_t        exp_q[$];
  logic [15:0] model [int];

  burst_mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every beat must match the head of the scoreboard, on the exact cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      exp_t e;
      checks++;
      beats_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat data=%h addr=%h last=%b cyc=%0d", rsp_data, rsp_addr, rsp_last, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_addr !== e.addr || rsp_last !== e.last || cyc !== e.cyc) begin
          errors++;
          $display("FAIL beat got data=%h addr=%h last=%b cyc=%0d, expected data=%h addr=%h last=%b cyc=%0d",
                   rsp_data, rsp_addr, rsp_last, cyc, e.data, e.addr, e.last, e.cyc);
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic do_req(input logic wr, input logic burst, input logic [15:0] addr,
                        input logic [15:0] wdata, output int acc);
    int   n;
    exp_t e;
    logic [15:0] base;
    logic [15:0] a;
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h ready=%b", addr, req_ready);
      req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (wr) begin
        model[int'(addr[15:1])] = wdata;
      end else if (burst) begin
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < BL; k++) begin
          a      = base | {12'h000, 3'(k), 1'b0};
          e.data = model[int'(a[15:1])];
          e.addr = a;
          e.last = (k == BL - 1);
          e.cyc  = acc + LAT + k;
          exp_q.push_back(e);
        end
      end else begin
        e.data = model[int'(addr[15:1])];
        e.addr = {addr[15:1], 1'b0};
        e.last = 1'b1;
        e.cyc  = acc + LAT;
        exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid !== 1'b0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d busy=%b rsp_valid=%b", exp_q.size(), busy, rsp_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++;
    if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    checks++;
    if (rsp_addr !== 16'h0000) begin errors++; $display("FAIL reset_rsp_addr got %h want 0000", rsp_addr); end
    checks++;
    if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got %b want 0", rsp_last); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_single_rw();
    int acc;
    int n;
    do_req(1'b1, 1'b0, 16'h0010, 16'h1234, acc);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, acc);
    n = 0;
    while (cyc < acc + LAT && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_beat_visible rsp_valid=%b busy=%b want 1 1", rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_drop rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    drain();
  endtask

  task automatic test_burst_wrap();
    int acc;
    for (int i = 0; i < BL; i++) begin
      do_req(1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'(16'hA000 + i), acc);
    end
    do_req(1'b0, 1'b1, 16'h0026, 16'h0000, acc);
    for (int i = 0; i < BL - 1; i++) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL burst_ready_low cycle %0d got %b want 0", i, req_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_return got %b want 1", req_ready); end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    do_req(1'b1, 1'b0, 16'h0012, 16'h3333, acc);
    do_req(1'b1, 1'b0, 16'h0014, 16'h4444, acc);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, acc);
    do_req(1'b0, 1'b0, 16'h0012, 16'h0000, acc);
    do_req(1'b0, 1'b0, 16'h0014, 16'h0000, acc);
    do_req(1'b0, 1'b1, 16'h002A, 16'h0000, acc);
    drain();
  endtask

  task automatic test_read_before_write();
    int acc;
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, acc);
    do_req(1'b1, 1'b0, 16'h0010, 16'h5555, acc);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, acc);
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    int b0;
    int n;
    int stray;
    b0 = beats_seen;
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, acc);
    n = 0;
    while (beats_seen < b0 + 3 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 30) begin errors++; $display("FAIL rst_wait_beats seen=%0d want %0d", beats_seen - b0, 3); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_rsp_valid got %b want 0", rsp_valid); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rst_stale_beats got %0d want 0", stray); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
  endtask

  task automatic test_held_write();
    int acc_b;
    int acc_w;
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, acc_b);
    do_req(1'b1, 1'b0, 16'h0030, 16'h7777, acc_w);
    checks++;
    if (acc_w != acc_b + BL) begin
      errors++;
      $display("FAIL held_write_accept got edge %0d want %0d", acc_w, acc_b + BL);
    end
    do_req(1'b0, 1'b0, 16'h0030, 16'h0000, acc_w);
    drain();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    beats_seen = 0;
    test_reset();
    test_single_rw();
    test_burst_wrap();
    test_back_to_back();
    test_read_before_write();
    test_reset_mid_burst();
    test_held_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
